// File: rtl/tcell_pkg.sv
// ============================================================================
//  Module      : tcell_pkg
//  Description : Shared state encoding and direction constants for the
//                toggle-cell counter sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tcell_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

`default_nettype wire

// File: rtl/toggle_cell.sv
// ============================================================================
//  Module      : toggle_cell
//  Description : Single-bit T flip-flop, asynchronous active-high reset to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module toggle_cell (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            q <= q ^ t;
        end
    end

endmodule

`default_nettype wire

// File: rtl/tcell_count_seq.sv
// ============================================================================
//  Module      : tcell_count_seq
//  Description : Clear-then-count sequencer driving a bank of toggle cells up
//                or down to a captured limit, with done and wrap pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tcell_count_seq
    import tcell_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dir,
    input  logic [WIDTH-1:0] limit,
    input  logic             hold,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             wrap,
    output logic [WIDTH-1:0] count
);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_limit;
    logic             r_dir;
    logic             r_wrap;
    logic [WIDTH-1:0] w_t;
    logic [WIDTH-1:0] w_up;
    logic [WIDTH-1:0] w_dn;
    logic             w_step;
    logic             w_busy;
    logic             w_done;
    logic             w_match;

    assign w_match = (count == r_limit);

    // Bit i toggles on an up step when all lower bits are 1, on a down step
    // when all lower bits are 0.
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_tvec
            if (i == 0) begin : g_lsb
                assign w_up[i] = 1'b1;
                assign w_dn[i] = 1'b1;
            end else begin : g_upper
                assign w_up[i] = &count[i-1:0];
                assign w_dn[i] = &(~count[i-1:0]);
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = CLEAR;
            CLEAR:   w_next = abort ? IDLE : RUN;
            RUN: begin
                if (abort) begin
                    w_next = IDLE;
                end else if (!hold && w_match) begin
                    w_next = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_t    = '0;
        w_step = 1'b0;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            CLEAR: begin
                w_busy = 1'b1;
                if (!abort) w_t = count;
            end
            RUN: begin
                w_busy = 1'b1;
                if (!abort && !hold && !w_match) begin
                    w_step = 1'b1;
                    w_t    = (r_dir == DIR_UP) ? w_up : w_dn;
                end
            end
            DONE:    w_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_limit <= '0;
            r_dir   <= DIR_DOWN;
        end else if (r_state == IDLE && start) begin
            r_limit <= limit;
            r_dir   <= dir;
        end
    end

    // A step wraps when every bit flips: all-ones going up, all-zeros going down.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_step & ((r_dir == DIR_UP) ? (&count) : ~(|count));
        end
    end

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_cell
            toggle_cell u_cell (
                .clk (clk),
                .rst (rst),
                .t   (w_t[i]),
                .q   (count[i])
            );
        end
    endgenerate

    assign busy = w_busy;
    assign done = w_done;
    assign wrap = r_wrap;

endmodule

`default_nettype wire

// File: tb/tb_tcell_count_seq.sv
// ============================================================================
//  Module      : tb_tcell_count_seq
//  Description : Scoreboard bench for tcell_count_seq with directed runs.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tcell_count_seq;
    import tcell_pkg::*;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic         dir;
    logic [W-1:0] limit;
    logic         hold;
    logic         abort;
    logic         busy;
    logic         done;
    logic         wrap;
    logic [W-1:0] count;

    typedef struct {
        logic [W-1:0] c;
        logic         b;
        logic         d;
        logic         w;
        int           tag;
    } exp_t;

    exp_t         trace_q[$];
    logic [W-1:0] done_q[$];
    int           n_chk;
    int           n_err;
    int           n_tag;
    logic         mon_en;

    tcell_count_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .dir   (dir),
        .limit (limit),
        .hold  (hold),
        .abort (abort),
        .busy  (busy),
        .done  (done),
        .wrap  (wrap),
        .count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one trace entry per cycle, plus a final-count check per done pulse.
    always @(negedge clk) begin
        if (mon_en) begin
            if (trace_q.size() > 0) begin
                exp_t e;
                e = trace_q.pop_front();
                n_chk++;
                if ({count, busy, done, wrap} !== {e.c, e.b, e.d, e.w}) begin
                    n_err++;
                    $display("FAIL trace#%0d: got count=%0d busy=%0b done=%0b wrap=%0b, want count=%0d busy=%0b done=%0b wrap=%0b",
                             e.tag, count, busy, done, wrap, e.c, e.b, e.d, e.w);
                end
            end
            if (done === 1'b1) begin
                n_chk++;
                if (done_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_done: got done=1 count=%0d, want no done", count);
                end else begin
                    logic [W-1:0] ec;
                    ec = done_q.pop_front();
                    if (count !== ec) begin
                        n_err++;
                        $display("FAIL done_count: got %0d, want %0d", count, ec);
                    end
                end
            end
        end
    end

    // Drive inputs for the next edge, then queue the outputs expected after it.
    task automatic tick(input logic st, input logic dr, input logic [W-1:0] lim,
                        input logic hd, input logic ab,
                        input logic [W-1:0] ec, input logic eb, input logic ed, input logic ew);
        exp_t e;
        start = st; dir = dr; limit = lim; hold = hd; abort = ab;
        @(posedge clk);
        #1;
        e.c = ec; e.b = eb; e.d = ed; e.w = ew; e.tag = n_tag;
        n_tag++;
        trace_q.push_back(e);
    endtask

    task automatic idle(input logic [W-1:0] ec, input logic eb, input logic ed, input logic ew);
        tick(1'b0, 1'b0, '0, 1'b0, 1'b0, ec, eb, ed, ew);
    endtask

    task automatic direct_check(input string name, input logic [W+2:0] want);
        n_chk++;
        if ({count, busy, done, wrap} !== want) begin
            n_err++;
            $display("FAIL %s: got {count,busy,done,wrap}=%b, want %b", name,
                     {count, busy, done, wrap}, want);
        end
    endtask

    initial begin
        n_chk = 0; n_err = 0; n_tag = 0; mon_en = 1'b0;
        rst = 1'b1; start = 1'b0; dir = 1'b0; limit = '0; hold = 1'b0; abort = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        direct_check("reset_state", {4'd0, 3'b000});
        rst = 1'b0;
        mon_en = 1'b1;

        // Up to 5 from 0; limit/dir wiggled after capture must be ignored.
        done_q.push_back(4'd5);
        tick(1'b1, DIR_UP, 4'd5, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, DIR_DOWN, 4'd1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        for (int v = 1; v <= 5; v++) idle(v[W-1:0], 1'b1, 1'b0, 1'b0);
        idle(4'd5, 1'b0, 1'b1, 1'b0);
        idle(4'd5, 1'b0, 1'b0, 1'b0);

        // Down to 13 from 5: clear, wrap 0->15, then 14, 13.
        done_q.push_back(4'd13);
        tick(1'b1, DIR_DOWN, 4'd13, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0);
        idle(4'd0,  1'b1, 1'b0, 1'b0);
        idle(4'd15, 1'b1, 1'b0, 1'b1);
        idle(4'd14, 1'b1, 1'b0, 1'b0);
        idle(4'd13, 1'b1, 1'b0, 1'b0);
        idle(4'd13, 1'b0, 1'b1, 1'b0);
        idle(4'd13, 1'b0, 1'b0, 1'b0);

        // Up to 9, leaving a non-zero count behind.
        done_q.push_back(4'd9);
        tick(1'b1, DIR_UP, 4'd9, 1'b0, 1'b0, 4'd13, 1'b1, 1'b0, 1'b0);
        idle(4'd0, 1'b1, 1'b0, 1'b0);
        for (int v = 1; v <= 9; v++) idle(v[W-1:0], 1'b1, 1'b0, 1'b0);
        idle(4'd9, 1'b0, 1'b1, 1'b0);
        idle(4'd9, 1'b0, 1'b0, 1'b0);

        // Up to 2 from 9: CLEAR takes 9 to 0 in one cycle.
        done_q.push_back(4'd2);
        tick(1'b1, DIR_UP, 4'd2, 1'b0, 1'b0, 4'd9, 1'b1, 1'b0, 1'b0);
        idle(4'd0, 1'b1, 1'b0, 1'b0);
        idle(4'd1, 1'b1, 1'b0, 1'b0);
        idle(4'd2, 1'b1, 1'b0, 1'b0);
        idle(4'd2, 1'b0, 1'b1, 1'b0);
        idle(4'd2, 1'b0, 1'b0, 1'b0);

        // Up to 5 with three hold cycles at count 3.
        done_q.push_back(4'd5);
        tick(1'b1, DIR_UP, 4'd5, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0);
        idle(4'd0, 1'b1, 1'b0, 1'b0);
        idle(4'd1, 1'b1, 1'b0, 1'b0);
        idle(4'd2, 1'b1, 1'b0, 1'b0);
        idle(4'd3, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) tick(1'b0, 1'b0, '0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0);
        idle(4'd4, 1'b1, 1'b0, 1'b0);
        idle(4'd5, 1'b1, 1'b0, 1'b0);
        idle(4'd5, 1'b0, 1'b1, 1'b0);
        idle(4'd5, 1'b0, 1'b0, 1'b0);

        // Abort (with hold) at count 2: no done, count frozen.
        tick(1'b1, DIR_UP, 4'd7, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0);
        idle(4'd0, 1'b1, 1'b0, 1'b0);
        idle(4'd1, 1'b1, 1'b0, 1'b0);
        idle(4'd2, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, '0, 1'b1, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
        idle(4'd2, 1'b0, 1'b0, 1'b0);

        // Rerun up to 1 after the abort.
        done_q.push_back(4'd1);
        tick(1'b1, DIR_UP, 4'd1, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0);
        idle(4'd0, 1'b1, 1'b0, 1'b0);
        idle(4'd1, 1'b1, 1'b0, 1'b0);
        idle(4'd1, 1'b0, 1'b1, 1'b0);
        idle(4'd1, 1'b0, 1'b0, 1'b0);

        // Abort during CLEAR: count left untouched.
        tick(1'b1, DIR_UP, 4'd3, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, '0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
        idle(4'd1, 1'b0, 1'b0, 1'b0);

        // Limit 0 counting down from 1: RUN matches immediately, no wrap.
        done_q.push_back(4'd0);
        tick(1'b1, DIR_DOWN, 4'd0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0);
        idle(4'd0, 1'b1, 1'b0, 1'b0);
        idle(4'd0, 1'b0, 1'b1, 1'b0);
        idle(4'd0, 1'b0, 1'b0, 1'b0);

        // start pulsed while busy is ignored; then async reset mid-RUN.
        tick(1'b1, DIR_UP, 4'd9, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        idle(4'd0, 1'b1, 1'b0, 1'b0);
        tick(1'b1, DIR_DOWN, 4'd1, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0);
        tick(1'b1, DIR_DOWN, 4'd1, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0);
        idle(4'd3, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        direct_check("pre_reset_run", {4'd3, 3'b100});
        rst = 1'b1;
        #1;
        direct_check("async_reset", {4'd0, 3'b000});
        @(posedge clk);
        #1;
        direct_check("reset_held", {4'd0, 3'b000});
        rst = 1'b0;
        idle(4'd0, 1'b0, 1'b0, 1'b0);
        idle(4'd0, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        n_chk++;
        if (trace_q.size() != 0 || done_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got trace=%0d done=%0d pending, want 0 and 0",
                     trace_q.size(), done_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tcell_count_seq.md
Name: tcell_count_seq

Overview:
- Sequencer for a bank of toggle cells (T flip-flops) that together form a WIDTH-bit counter register.
- On a start request it clears the bank, then counts up or down one step per cycle until the count equals a programmed limit, and signals completion with a one-cycle done pulse.
- All count-register changes are made only by driving per-bit toggle enables; the bits are never loaded directly.
- Used as the basic run-length/timer engine wherever a toggle-cell counter is needed.

Parameters:
- WIDTH, 4, number of toggle cells in the counter bank (must be ≥ 2).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  begin a run; sampled only in IDLE.
- dir  input  1  count direction: 1 = up, 0 = down; captured with start.
- limit  input  WIDTH  terminal count value; captured with start.
- hold  input  1  pause counting while high; RUN state only.
- abort  input  1  cancel the run; no done pulse is produced.
- busy  output  1  high in the CLEAR and RUN states.
- done  output  1  one-cycle pulse in the DONE state.
- wrap  output  1  registered one-cycle pulse when the count wraps.
- count  output  WIDTH  current toggle-bank value.

Behaviour:
- Reset (asynchronous): state = IDLE; count, busy, done and wrap all 0; captured limit_r and dir_r cleared to 0.
- FSM states: IDLE, CLEAR, RUN, DONE. busy and done are Moore decodes of the registered state.
- Toggle vector t[WIDTH-1:0] drives the bank. Each cell does q <= q ^ t[i]. t defaults to 0 in every state.
- IDLE:
  - start=1 at edge E0: capture limit_r <= limit and dir_r <= dir; go to CLEAR. busy reads 1 after E0.
  - count is held.
- CLEAR:
  - t = count, so every 1 bit toggles to 0.
  - At E1: count = 0; go to RUN.
  - If count is already 0, t = 0 and CLEAR still takes one cycle.
- RUN, priority order abort > hold > compare > step:
  - abort=1: t = 0; go to IDLE. count is frozen at its current value, done stays 0.
  - hold=1: t = 0; stay in RUN.
  - count == limit_r: t = 0; go to DONE.
  - Otherwise, up step: t[0] = 1; t[i] = AND of count[i-1:0].
  - Otherwise, down step: t[0] = 1; t[i] = AND of ~count[i-1:0].
- Abort in CLEAR: go to IDLE without toggling.
- DONE: busy = 0, done = 1 for exactly one cycle; unconditional return to IDLE. start is ignored here.
- start is ignored in CLEAR, RUN and DONE. limit and dir changes after capture have no effect.
- wrap is registered and high for the cycle after any step that takes count from all-ones to 0 (up) or from 0 to all-ones (down).
- Latency, up count to limit L: count = L after E(1+L); DONE after E(2+L); done is high during the cycle that follows.
- Latency, down count to limit L: count reaches L after E(1 + ((2^WIDTH − L) mod 2^WIDTH)); DONE one edge later.
- Each hold cycle adds exactly one cycle of latency.
- Limit 0: RUN matches immediately; DONE after E2. No toggling occurs in RUN.
- rst asserted mid-run: immediate return to reset values; no done pulse.
- count is the toggle bank's q vector; it is not separately registered.

Decomposition:
- Shared package tcell_pkg:
  - state enum: IDLE, CLEAR, RUN, DONE (2 bits).
  - constants DIR_UP = 1, DIR_DOWN = 0.
- Sub-module toggle_cell: single-bit T flip-flop with asynchronous active-high reset to 0 and inputs t, clk, rst; output q.
  - Instantiated WIDTH times with a generate loop.
  - The sequencer contains only the FSM, the capture registers, toggle-vector logic and the wrap register.

Test Plan:
- Up count, WIDTH=4, limit=5, dir=1, start at E0 → count follows 0,1,2,3,4,5 after E1..E6; done high during the cycle after E7; busy high E0..E7; wrap never asserts.
- Down count, limit=13, dir=0 → count goes 0,15,14,13; wrap pulses once after the 0→15 step; done after DONE is entered at E5.
- Non-zero start value: finish a run at count=9, then start up with limit=2 → CLEAR takes count 9→0 in one cycle, then 1, 2, then done.
- hold high for 3 cycles in RUN at count=3, limit=5 → count stays at 3 for 3 cycles; done arrives exactly 3 cycles later than the no-hold run.
- abort at count=2 (with hold also high) → IDLE on the next edge; count frozen at 2; done never asserts; a subsequent start clears and reruns.
- start pulsed while busy, and rst asserted asynchronously mid-RUN → the start has no effect; after rst, count=0, busy=0, done=0, wrap=0 immediately, without waiting for a clock edge.
